// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker: reference-function modes and FSM states.
package gate_sweep_pkg;

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational reference model for N-input reduction gates (AND/OR/XOR/NOR).
module gate_sweep_ref
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_INPUTS = 5
) (
    input  logic [N_INPUTS-1:0] vec_i,
    input  logic [1:0]          mode_i,
    output logic                expected_o
);

    always_comb begin
        expected_o = 1'b0;
        case (mode_i)
            MODE_AND: expected_o = &vec_i;
            MODE_OR:  expected_o = |vec_i;
            MODE_XOR: expected_o = ^vec_i;
            MODE_NOR: expected_o = ~|vec_i;
            default:  expected_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine: sweeps every input vector onto a gate under test and
// compares its output against the reference model, recording errors and first failure.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_INPUTS    = 5,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                dut_o,
    output logic [N_INPUTS-1:0] vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                first_fail_valid
);

    localparam int unsigned        HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] VEC_LAST = '1;

    state_e                state_q, state_d;
    logic [N_INPUTS-1:0]   vec_q, vec_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [1:0]            mode_q, mode_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [N_INPUTS-1:0]   ffv_q, ffv_d;
    logic                  ffvalid_q, ffvalid_d;
    logic                  expected;
    logic                  mismatch;

    gate_sweep_ref #(.N_INPUTS(N_INPUTS)) u_ref (
        .vec_i      (vec_q),
        .mode_i     (mode_q),
        .expected_o (expected)
    );

    assign mismatch = (dut_o != expected);

    // Next-state and result update; comparison happens on the last hold cycle of each vector.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        mode_d    = mode_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_APPLY;
                    mode_d    = mode;
                    vec_d     = '0;
                    hold_d    = '0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            ST_APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    if (mismatch) begin
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!ffvalid_q) begin
                            ffv_d     = vec_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    // Terminal detect by all-ones compare so the counter never wraps.
                    if (vec_q == VEC_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        vec_d  = vec_q + N_INPUTS'(1);
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            hold_q    <= '0;
            mode_q    <= MODE_AND;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            hold_q    <= hold_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign vec              = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench: three checker instances (HOLD=1/ERR_W=8, ERR_W=4, HOLD=3) against modelled gates.
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    typedef struct {
        logic pass;
        int   err;
        int   ffv;
        logic ffvalid;
    } exp_t;

    localparam int K_AND5 = 0;
    localparam int K_ST0  = 1;
    localparam int K_ST1  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic       rst0, rst1, rst2;
    logic       start0, start1, start2;
    logic [1:0] mode0, mode1, mode2;
    int         kind0, kind1, kind2;
    logic       dut0, dut1, dut2;
    logic [4:0] vec0, vec1, vec2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       pass0, pass1, pass2;
    logic [7:0] err0, err2;
    logic [3:0] err1;
    logic [4:0] ffv0, ffv1, ffv2;
    logic       ffvalid0, ffvalid1, ffvalid2;

    function automatic logic model_gate(input int kind, input logic [4:0] v);
        case (kind)
            K_AND5:  return &v;
            K_ST0:   return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign dut0 = model_gate(kind0, vec0);
    assign dut1 = model_gate(kind1, vec1);
    assign dut2 = model_gate(kind2, vec2);

    gate_sweep_checker #(.N_INPUTS(5), .HOLD_CYCLES(1), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst0), .start(start0), .mode(mode0), .dut_o(dut0),
        .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffv0), .first_fail_valid(ffvalid0));

    gate_sweep_checker #(.N_INPUTS(5), .HOLD_CYCLES(1), .ERR_W(4)) u1 (
        .clk(clk), .rst(rst1), .start(start1), .mode(mode1), .dut_o(dut1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail_vec(ffv1), .first_fail_valid(ffvalid1));

    gate_sweep_checker #(.N_INPUTS(5), .HOLD_CYCLES(3), .ERR_W(8)) u2 (
        .clk(clk), .rst(rst2), .start(start2), .mode(mode2), .dut_o(dut2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffvalid2));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_result(input string name, input exp_t e,
                              input logic p, input int er, input int fv, input logic fvv);
        chk({name, "_pass"}, int'(p), int'(e.pass));
        chk({name, "_err"}, er, e.err);
        chk({name, "_ffv"}, fv, e.ffv);
        chk({name, "_ffvalid"}, int'(fvv), int'(e.ffvalid));
    endtask

    // Monitors: vec stepping, busy length, single-cycle done, and scoreboard pop on done.
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (busy0 === 1'b1) begin
            chk("u0_vec_step", int'(vec0), cnt0);
            cnt0++;
        end
        if (done0 === 1'b1) begin
            chk("u0_done_busy_low", int'(busy0), 0);
            chk("u0_busy_len", cnt0, 32);
            chk("u0_done_single", int'(pd0), 0);
            if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
            else begin
                e = q0.pop_front();
                chk_result("u0", e, pass0, int'(err0), int'(ffv0), ffvalid0);
            end
        end
        if (busy0 !== 1'b1 && done0 !== 1'b1) cnt0 = 0;
        pd0 = (done0 === 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy1 === 1'b1) cnt1++;
        if (done1 === 1'b1) begin
            chk("u1_busy_len", cnt1, 32);
            chk("u1_done_single", int'(pd1), 0);
            if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                chk_result("u1", e, pass1, int'(err1), int'(ffv1), ffvalid1);
            end
        end
        if (busy1 !== 1'b1 && done1 !== 1'b1) cnt1 = 0;
        pd1 = (done1 === 1'b1);
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy2 === 1'b1) begin
            if (cnt2 % 3 == 0) chk("u2_vec_hold", int'(vec2), cnt2 / 3);
            cnt2++;
        end
        if (done2 === 1'b1) begin
            chk("u2_busy_len", cnt2, 96);
            chk("u2_done_single", int'(pd2), 0);
            if (q2.size() == 0) chk("u2_unexpected_done", 1, 0);
            else begin
                e = q2.pop_front();
                chk_result("u2", e, pass2, int'(err2), int'(ffv2), ffvalid2);
            end
        end
        if (busy2 !== 1'b1 && done2 !== 1'b1) cnt2 = 0;
        pd2 = (done2 === 1'b1);
    end

    function automatic logic done_of(input int w);
        case (w)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    task automatic launch(input int w, input logic [1:0] m, input int k,
                          input logic push, input exp_t e);
        case (w)
            0: begin if (push) q0.push_back(e); mode0 = m; kind0 = k; start0 = 1'b1; end
            1: begin if (push) q1.push_back(e); mode1 = m; kind1 = k; start1 = 1'b1; end
            default: begin if (push) q2.push_back(e); mode2 = m; kind2 = k; start2 = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int w, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (done_of(w) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic p, input int er, input int fv, input logic fvv);
        exp_t e;
        e.pass = p; e.err = er; e.ffv = fv; e.ffvalid = fvv;
        return e;
    endfunction

    initial begin
        logic reached;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0 = MODE_AND; mode1 = MODE_AND; mode2 = MODE_AND;
        kind0 = K_AND5; kind1 = K_AND5; kind2 = K_AND5;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        chk("rst_vec", int'(vec0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_ffv", int'(ffv0), 0);
        chk("rst_ffvalid", int'(ffvalid0), 0);

        // AND mode, ideal AND5.
        launch(0, MODE_AND, K_AND5, 1'b1, mk(1'b1, 0, 0, 1'b0));
        wait_done(0, "and_ideal");

        // OR mode, stuck-at-0: vectors 1..31 mismatch.
        launch(0, MODE_OR, K_ST0, 1'b1, mk(1'b0, 31, 1, 1'b1));
        wait_done(0, "or_st0");
        repeat (3) @(posedge clk);
        #1;
        chk("hold_vec", int'(vec0), 31);
        chk("hold_err", int'(err0), 31);
        chk("hold_pass", int'(pass0), 0);
        chk("hold_busy", int'(busy0), 0);

        // XOR mode, DUT is AND5: 15 odd-parity vectors differ, 11111 agrees.
        launch(0, MODE_XOR, K_AND5, 1'b1, mk(1'b0, 15, 1, 1'b1));
        wait_done(0, "xor_and5");

        // NOR mode, stuck-at-0: only vector 0 differs.
        launch(0, MODE_NOR, K_ST0, 1'b1, mk(1'b0, 1, 0, 1'b1));
        wait_done(0, "nor_st0");

        // Abort mid-sweep at vec 10; no expectation pushed so any done pulse is flagged.
        launch(0, MODE_OR, K_ST0, 1'b0, mk(1'b0, 0, 0, 1'b0));
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (vec0 == 5'd10) begin
                reached = 1'b1;
                break;
            end
        end
        chk("abort_reached_vec10", int'(reached), 1);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_vec", int'(vec0), 0);
        chk("abort_err", int'(err0), 0);
        chk("abort_ffvalid", int'(ffvalid0), 0);
        chk("abort_done", int'(done0), 0);
        repeat (5) @(posedge clk);
        #1;
        launch(0, MODE_AND, K_AND5, 1'b1, mk(1'b1, 0, 0, 1'b0));
        wait_done(0, "after_abort");

        // ERR_W=4: 31 mismatches saturate at 15.
        launch(1, MODE_AND, K_ST1, 1'b1, mk(1'b0, 15, 0, 1'b1));
        wait_done(1, "sat_st1");

        // HOLD=3 with stray start and mode toggling mid-sweep.
        launch(2, MODE_AND, K_AND5, 1'b1, mk(1'b1, 0, 0, 1'b0));
        repeat (10) @(posedge clk);
        #1;
        mode2 = MODE_OR;
        repeat (10) @(posedge clk);
        #1;
        start2 = 1'b1;
        mode2 = MODE_XOR;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        wait_done(2, "hold3_and");

        launch(2, MODE_OR, K_ST0, 1'b1, mk(1'b0, 31, 1, 1'b1));
        wait_done(2, "hold3_or_st0");

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Synthesizable, self-checking exhaustive stimulus engine for N-input reduction gates (AND/OR/XOR/NOR families).
- Sweeps every input combination 0..2^N_INPUTS-1 onto the DUT inputs and compares the DUT output against an internal reference.
- Reports pass/fail, a saturating mismatch count and the first failing vector.
- Sits beside any AND/OR-style gate under test, in simulation or on hardware.

Parameters:
N_INPUTS, 5, number of DUT inputs swept (legal 2..16)
HOLD_CYCLES, 1, cycles each vector is held before the DUT output is sampled (legal >=1)
ERR_W, 8, width of the mismatch counter

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep (accepted only in IDLE)
mode  input  2  reference function: 00 AND, 01 OR, 10 XOR, 11 NOR
dut_o  input  1  DUT output (DUT is combinational on vec)
vec  output  N_INPUTS  stimulus driven to DUT; vec[0] maps to DUT input 1
busy  output  1  high while a sweep is running
done  output  1  single-cycle pulse at sweep end
pass  output  1  1 when the last completed sweep had zero mismatches
err_count  output  ERR_W  mismatches in the current/last sweep, saturating
first_fail_vec  output  N_INPUTS  first vector that mismatched
first_fail_valid  output  1  first_fail_vec holds a valid value

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, hold counter=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE: start=1 moves to APPLY on the next edge. On that edge:
  - mode is latched; later mode changes are ignored until the next start.
  - vec=0, hold counter=0, busy=1.
  - err_count, first_fail_*, pass are cleared.
- APPLY: the vector is held HOLD_CYCLES cycles. On the cycle where hold counter == HOLD_CYCLES-1:
  - dut_o is compared with ref(vec, latched mode).
  - Mismatch: err_count increments, saturating at 2^ERR_W-1. If first_fail_valid=0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec == 2^N_INPUTS-1, go to DONE. Otherwise vec increments and the hold counter returns to 0.
- DONE: exactly one cycle.
  - done=1, busy=0, pass=(err_count==0 including the final comparison).
  - Returns to IDLE.
- Timing: busy is high for exactly 2^N_INPUTS*HOLD_CYCLES cycles, and done follows on the next cycle.
- vec holds its last value (all ones) after the sweep until the next start.
- Results (pass, err_count, first_fail_*) hold until the next accepted start or reset.
- start is ignored in APPLY and DONE; there is no queuing.
- Reset mid-sweep: all registers return to reset values on that edge. No done pulse is issued.
- Reference function: AND = &vec, OR = |vec, XOR = ^vec, NOR = ~|vec.
- The vector counter is N_INPUTS wide. Terminal detection uses the all-ones compare, not wrap-around.

Decomposition:
- Shared package gate_sweep_pkg holds:
  - mode encodings MODE_AND=2'b00, MODE_OR=2'b01, MODE_XOR=2'b10, MODE_NOR=2'b11
  - FSM state encodings
- One sub-module, gate_sweep_ref: a combinational reference model (vec, mode -> expected). It is reusable by other benches.
- Counter, hold timer and FSM stay in the top module.

Test Plan:
- N=5, HOLD=1, mode AND, DUT = ideal AND5, start pulse -> vec steps 0..31 one per cycle; busy high 32 cycles; done pulse on cycle 33; pass=1, err_count=0, first_fail_valid=0.
- mode OR, DUT output stuck at 0 -> err_count=31, first_fail_vec=5'b00001, pass=0.
- mode XOR, DUT = AND5 -> err_count=15, first_fail_vec=5'b00001, pass=0 (vector 11111 matches).
- ERR_W=4, mode AND, DUT stuck at 1 -> 31 mismatches saturate to err_count=15; first_fail_vec=0.
- HOLD=3 -> vec changes every 3 cycles; busy high 96 cycles. start pulses during busy are ignored. mode toggled mid-sweep has no effect on results.
- rst asserted when vec=10 -> next cycle busy=0, vec=0, err_count=0, no done pulse. A fresh start then completes a normal 32-vector sweep.
